// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin owner of a shared active-low 2-to-4 select, with a park cycle between grants.
// Define ARB_HOLD_LIMIT_EN to force a release after HOLD_MAX grant cycles when others are waiting.
module rr_decode_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_i,
   output logic       grant_valid_o,
   output logic [1:0] grant_sel_o,
   output logic [3:0] grant_n_o,
   output logic       timeout_o
);
   typedef enum logic [1:0] {IDLE, GRANT, PARK} state_t;
   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d, last_q, last_d, win;
   logic       timeout_q, timeout_d, drop, expire, release_w;
   if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold
      $error("HOLD_MAX must be within 2..15");
   end
   // descending offsets so the nearest requester after last_q wins; last_q itself ranks lowest
   always_comb begin
      win = last_q;
      for (int i = 4; i >= 1; i--) if (req_i[last_q + 2'(i)]) win = last_q + 2'(i);
   end
   assign drop = !req_i[sel_q];
`ifdef ARB_HOLD_LIMIT_EN
   logic [3:0] cnt_q, cnt_d;
   assign expire = cnt_q >= 4'(HOLD_MAX - 1) && |(req_i & ~(4'b0001 << sel_q));
   assign cnt_d  = state_q != GRANT ? 4'd0 : cnt_q + 4'(cnt_q != 4'hf);
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 4'd0;
      else     cnt_q <= cnt_d;
   end
`else
   assign expire = 1'b0;
`endif
   assign release_w = state_q == GRANT && (drop || expire);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= 2'd0;
         last_q    <= 2'd3;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
      end
   end
   always_comb begin
      state_d   = state_q == GRANT ? (release_w ? PARK : GRANT) : (|req_i ? GRANT : IDLE);
      sel_d     = state_q != GRANT && |req_i ? win : sel_q;
      last_d    = release_w ? sel_q : last_q;
      timeout_d = release_w && !drop;
   end
   always_comb begin
      grant_valid_o = state_q == GRANT;
      grant_sel_o   = sel_q;
      grant_n_o     = state_q == GRANT ? ~(4'b0001 << sel_q) : 4'b1111;
      timeout_o     = timeout_q;
   end
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed and randomized checks against a behavioural round-robin model.
module tb_rr_decode_arbiter;
   localparam int HOLD_MAX = 8;
`ifdef ARB_HOLD_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req_i = 4'd0;
   logic       grant_valid_o, timeout_o;
   logic [1:0] grant_sel_o;
   logic [3:0] grant_n_o;
   int checks = 0, errors = 0;
   int m_owner, m_sel, m_last, m_held;
   bit m_park, m_to;

   rr_decode_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .grant_valid_o(grant_valid_o),
      .grant_sel_o(grant_sel_o), .grant_n_o(grant_n_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   function automatic int pick(input int last, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   // one clock edge of the reference: owner id (-1 none), park flag, cycles held so far
   task automatic tick(input logic [3:0] r, input logic rs);
      logic [3:0] others;
      m_to = 1'b0;
      if (rs) begin
         m_owner = -1; m_sel = 0; m_last = 3; m_held = 0; m_park = 1'b0;
      end else if (m_park || m_owner < 0) begin
         m_park  = 1'b0;
         m_owner = pick(m_last, r);
         if (m_owner >= 0) begin m_sel = m_owner; m_held = 1; end
      end else begin
         others = r;
         others[m_owner] = 1'b0;
         if (!r[m_owner] || (LIMIT && m_held >= HOLD_MAX && others != 0)) begin
            m_to    = r[m_owner];
            m_last  = m_owner;
            m_park  = 1'b1;
            m_owner = -1;
         end else m_held++;
      end
   endtask

   task automatic step(input logic [3:0] r, input logic rs);
      logic [3:0] e;
      req_i = r;
      rst   = rs;
      @(posedge clk);
      tick(r, rs);
      #1;
      e = 4'hf;
      if (m_owner >= 0) e[m_owner] = 1'b0;
      check("valid", 32'(grant_valid_o), 32'(m_owner >= 0));
      if (m_owner >= 0 || rs) check("sel", 32'(grant_sel_o), 32'(m_sel));
      check("grant_n", 32'(grant_n_o), 32'(e));
      check("timeout", 32'(timeout_o), 32'(m_to));
      check("onehot", 32'($countones(~grant_n_o) <= 1), 32'd1);
   endtask

   task automatic rand_run(input int n, input int drop_mod, input int rise_pct);
      logic [3:0] r = 4'd0;
      repeat (n) begin
         for (int i = 0; i < 4; i++)
            if (m_owner == i && $urandom_range(drop_mod - 1) == 0) r[i] = 1'b0;
            else if (!r[i] && $urandom_range(99) < rise_pct) r[i] = 1'b1;
            else if (r[i] && m_owner != i && $urandom_range(19) == 0) r[i] = 1'b0;
         step(r, $urandom_range(199) == 0);
      end
   endtask

   initial begin
      logic [3:0] r;
      int order[$];
      int tos;
      bit prev_v;
      step(4'd0, 1'b1);
      step(4'd0, 1'b1);
      step(4'b0010, 1'b0);
      check("t1_sel", 32'(grant_sel_o), 32'd1);
      step(4'd0, 1'b0);
      step(4'd0, 1'b0);
      // each owner drops two cycles after its grant, everyone else keeps asking
      step(4'd0, 1'b1);
      r = 4'hf;
      prev_v = 1'b0;
      for (int c = 0; c < 24; c++) begin
         step(r, 1'b0);
         if (grant_valid_o && !prev_v) order.push_back(int'(grant_sel_o));
         prev_v = grant_valid_o;
         r = 4'hf;
         if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
      end
      check("t2_count", 32'(order.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < order.size(); k++) check("t2_order", 32'(order[k]), 32'(k % 4));
      step(4'd0, 1'b1);
      tos = 0;
      repeat (20) begin step(4'b0011, 1'b0); tos += int'(timeout_o); end
      check("t3_timeouts", 32'(tos), LIMIT ? 32'd2 : 32'd0);
      step(4'd0, 1'b1);
      tos = 0;
      repeat (20) begin step(4'b0001, 1'b0); tos += int'(timeout_o); end
      check("t4_timeouts", 32'(tos), 32'd0);
      check("t4_owner", 32'(grant_sel_o), 32'd0);
      step(4'd0, 1'b1);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b1);
      check("t5_released", 32'(grant_n_o), 32'hf);
      step(4'd0, 1'b0);
      step(4'b0100, 1'b0);
      check("t5_regrant", 32'(grant_sel_o), 32'd2);
      step(4'd0, 1'b1);
      repeat (3) step(4'b1000, 1'b0);
      step(4'b0001, 1'b0);
      check("t6_park", 32'(grant_n_o), 32'hf);
      step(4'b0001, 1'b0);
      check("t6_wrap", 32'(grant_n_o), 32'b1110);
      step(4'd0, 1'b1);
      rand_run(600, 3, 40);
      rand_run(600, 12, 25);
      rand_run(400, 30, 60);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1);
   end
endmodule
